// File: rtl/pad_loop_sequencer.sv
// Pad loop sequencer: records debounced pad presses into a circular step
// memory and replays them as a pad code, per-pad LEDs and a piezo tone.
//
// state   | meaning
// IDLE    | stopped; step, timer and code held at 0
// PLAY    | looping through the step memory, driving code, LEDs and tone
// RECORD  | looping as in PLAY, capturing the first press of each step
// CLEAR   | zeroing the step memory, one entry per cycle; inputs ignored
module pad_loop_sequencer #(
    parameter int NUM_PADS  = 12,
    parameter int CODE_W    = $clog2(NUM_PADS + 1),
    parameter int STEPS     = 16,
    parameter int STEP_DIV  = 4096,
    parameter int TONE_BASE = 64,
    parameter int TONE_STEP = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_PADS-1:0]      btn,
    input  logic                     play_en,
    input  logic                     rec_en,
    input  logic                     clear,
    output logic [CODE_W-1:0]        Dout,
    output logic                     Pout,
    output logic [NUM_PADS-1:0]      pad_led,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     playing,
    output logic                     recording,
    output logic                     busy
);
    localparam int IDX_W   = $clog2(STEPS);
    localparam int TIMER_W = $clog2(STEP_DIV);
    localparam int TONE_W  = $clog2(TONE_BASE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_REC   = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic [1:0]          state, state_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic [IDX_W-1:0]    step_nxt, step_adv, clr_idx, clr_nxt;
    logic [CODE_W-1:0]   dout_nxt;
    logic [CODE_W-1:0]   mem [STEPS];
    logic [NUM_PADS-1:0] btn_q, edge_vec;
    logic                pend_v, pend_v_nxt, cap_v;
    logic [CODE_W-1:0]   pend_c, cap_c;
    logic                tc, stay_rec, mem_we;
    logic [IDX_W-1:0]    mem_wa;
    logic [CODE_W-1:0]   mem_wd;
    logic [TONE_W-1:0]   tone_cnt, half;

    // Lowest pressed pad wins when several rise together.
    function automatic logic [CODE_W-1:0] first_code(input logic [NUM_PADS-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (v[i]) r = CODE_W'(i + 1);
        end
        return r;
    endfunction

    // Press capture: an edge only counts if nothing is pending for this step yet.
    always_comb begin
        edge_vec = btn & ~btn_q;
        cap_v    = pend_v;
        cap_c    = pend_c;
        if (!pend_v && (edge_vec != '0)) begin
            cap_v = 1'b1;
            cap_c = first_code(edge_vec);
        end
    end

    // Mode transitions, priority clear > rec_en > play_en.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clear)        state_nxt = S_CLEAR;
                else if (rec_en)  state_nxt = S_REC;
                else if (play_en) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (clear)         state_nxt = S_CLEAR;
                else if (rec_en)   state_nxt = S_REC;
                else if (!play_en) state_nxt = S_IDLE;
            end
            S_REC: begin
                if (clear)        state_nxt = S_CLEAR;
                else if (!rec_en) state_nxt = play_en ? S_PLAY : S_IDLE;
            end
            default: begin
                if (clr_idx == IDX_W'(STEPS - 1)) state_nxt = S_IDLE;
            end
        endcase
    end

    // Step timer, step index, code register and memory write selection.
    always_comb begin
        tc        = (timer == TIMER_W'(STEP_DIV - 1));
        step_adv  = (step_idx == IDX_W'(STEPS - 1)) ? '0 : step_idx + 1'b1;
        stay_rec  = (state == S_REC) && (state_nxt == S_REC);
        step_nxt  = step_idx;
        timer_nxt = timer;
        dout_nxt  = Dout;
        if (state_nxt == S_IDLE || state_nxt == S_CLEAR) begin
            step_nxt  = '0;
            timer_nxt = '0;
            dout_nxt  = '0;
        end else if (state == S_IDLE) begin
            step_nxt  = '0;
            timer_nxt = '0;
            dout_nxt  = mem[0];
        end else if (tc) begin
            timer_nxt = '0;
            step_nxt  = step_adv;
            dout_nxt  = mem[step_adv];
        end else begin
            timer_nxt = timer + 1'b1;
        end
        // Pending is dropped at every step end and whenever RECORD is left.
        pend_v_nxt = stay_rec && !tc && cap_v;
        clr_nxt    = (state == S_CLEAR) ? clr_idx + 1'b1 : '0;
        mem_we     = (state == S_CLEAR) || (stay_rec && tc && cap_v);
        mem_wa     = (state == S_CLEAR) ? clr_idx : step_idx;
        mem_wd     = (state == S_CLEAR) ? '0 : cap_c;
    end

    // Control and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            step_idx <= '0;
            timer    <= '0;
            Dout     <= '0;
            btn_q    <= '0;
            pend_v   <= 1'b0;
            pend_c   <= '0;
            clr_idx  <= '0;
        end else begin
            state    <= state_nxt;
            step_idx <= step_nxt;
            timer    <= timer_nxt;
            Dout     <= dout_nxt;
            btn_q    <= btn;
            pend_v   <= pend_v_nxt;
            pend_c   <= cap_c;
            clr_idx  <= clr_nxt;
        end
    end

    // Step memory; reset wipes it so an aborted capture never lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < STEPS; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Piezo square wave; restarts low whenever the code changes or is rest.
    always_comb half = TONE_W'(TONE_BASE - TONE_STEP * int'(Dout));

    always_ff @(posedge CLK) begin
        if (RST) begin
            tone_cnt <= '0;
            Pout     <= 1'b0;
        end else if (Dout == '0 || dout_nxt != Dout) begin
            tone_cnt <= '0;
            Pout     <= 1'b0;
        end else if (tone_cnt == half - TONE_W'(1)) begin
            tone_cnt <= '0;
            Pout     <= ~Pout;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    // LED for the current code, plus live pads while recording.
    always_comb begin
        pad_led = '0;
        if (state == S_PLAY || state == S_REC) begin
            if (Dout != '0) pad_led = NUM_PADS'(1) << (Dout - 1'b1);
            if (state == S_REC) pad_led = pad_led | btn;
        end
    end

    assign playing   = (state == S_PLAY) || (state == S_REC);
    assign recording = (state == S_REC);
    assign busy      = (state == S_CLEAR);

endmodule

// File: tb/tb_pad_loop_sequencer.sv
// Bench for pad_loop_sequencer: directed record/play/clear/reset scenarios
// followed by random traffic, all checked every cycle against a loop model.
module tb_pad_loop_sequencer;
    localparam int NP     = 12;
    localparam int ST     = 4;
    localparam int SD     = 256;
    localparam int TONE_B = 64;
    localparam int TONE_S = 4;
    localparam int MI = 0, MP = 1, MR = 2, MC = 3;

    logic          CLK, RST, play_en, rec_en, clear;
    logic [NP-1:0] btn;
    logic [3:0]    Dout;
    logic          Pout, playing, recording, busy;
    logic [NP-1:0] pad_led;
    logic [1:0]    step_idx;

    int tests = 0;
    int fails = 0;

    pad_loop_sequencer #(
        .NUM_PADS(NP), .STEPS(ST), .STEP_DIV(SD),
        .TONE_BASE(TONE_B), .TONE_STEP(TONE_S)
    ) dut (
        .CLK(CLK), .RST(RST), .btn(btn), .play_en(play_en), .rec_en(rec_en),
        .clear(clear), .Dout(Dout), .Pout(Pout), .pad_led(pad_led),
        .step_idx(step_idx), .playing(playing), .recording(recording), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a loop position counter over STEPS*STEP_DIV cycles, a code array,
    // and the age of the current code for the tone.
    int            m_mode, m_phase, m_pend, m_clr_left, m_dout, m_age, m_old;
    int            m_mem [ST];
    logic [NP-1:0] m_btn_q, m_edges;

    function automatic int low_code(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i + 1;
        return 0;
    endfunction

    task automatic m_enter_clear();
        m_mode = MC;
        m_clr_left = ST;
        m_phase = 0;
        m_pend = 0;
        for (int i = 0; i < ST; i++) m_mem[i] = 0;
    endtask

    task automatic m_adv();
        m_phase = (m_phase + 1) % (ST * SD);
    endtask

    always @(posedge CLK) begin
        m_old = m_dout;
        if (RST) begin
            m_mode = MI; m_phase = 0; m_pend = 0; m_clr_left = 0; m_btn_q = '0;
            for (int i = 0; i < ST; i++) m_mem[i] = 0;
        end else begin
            m_edges = btn & ~m_btn_q;
            case (m_mode)
                MI: begin
                    if (clear) m_enter_clear();
                    else if (rec_en) begin m_mode = MR; m_phase = 0; end
                    else if (play_en) begin m_mode = MP; m_phase = 0; end
                end
                MP: begin
                    if (clear) m_enter_clear();
                    else if (rec_en) begin m_mode = MR; m_adv(); end
                    else if (!play_en) begin m_mode = MI; m_phase = 0; end
                    else m_adv();
                end
                MR: begin
                    if (clear) m_enter_clear();
                    else if (!rec_en) begin
                        m_pend = 0;
                        if (play_en) begin m_mode = MP; m_adv(); end
                        else begin m_mode = MI; m_phase = 0; end
                    end else begin
                        if (m_pend == 0 && m_edges != '0) m_pend = low_code(m_edges);
                        if ((m_phase % SD) == SD - 1) begin
                            if (m_pend != 0) m_mem[m_phase / SD] = m_pend;
                            m_pend = 0;
                        end
                        m_adv();
                    end
                end
                default: begin
                    m_clr_left--;
                    if (m_clr_left == 0) m_mode = MI;
                end
            endcase
            m_btn_q = btn;
        end
        m_dout = (m_mode == MP || m_mode == MR) ? m_mem[m_phase / SD] : 0;
        m_age = (m_dout != m_old) ? 0 : m_age + 1;
    end

    function automatic int exp_led();
        int v;
        v = (m_dout != 0) ? (1 << (m_dout - 1)) : 0;
        if (m_mode == MR) v = v | int'(btn);
        return v;
    endfunction

    function automatic int exp_pout();
        if (m_dout == 0) return 0;
        return ((m_age / (TONE_B - m_dout * TONE_S)) % 2);
    endfunction

    // Every-cycle comparison against the model.
    always @(posedge CLK) begin
        #2;
        chk("Dout", int'(Dout), m_dout);
        chk("step_idx", int'(step_idx), m_phase / SD);
        chk("playing", int'(playing), int'(m_mode == MP || m_mode == MR));
        chk("recording", int'(recording), int'(m_mode == MR));
        chk("busy", int'(busy), int'(m_mode == MC));
        chk("pad_led", int'(pad_led), exp_led());
        chk("Pout", int'(Pout), exp_pout());
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic align_to_step(input int target, output bit ok);
        int prev;
        ok = 1'b0;
        prev = int'(step_idx);
        for (int i = 0; i < 4 * ST * SD && !ok; i++) begin
            @(posedge CLK); #3;
            if (int'(step_idx) == target && prev != target) ok = 1'b1;
            prev = int'(step_idx);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL align: step %0d never reached, at step %0d", target, prev);
        end
    endtask

    int exp_code  [4] = '{1, 3, 2, 12};
    int exp_ledv  [4] = '{12'h001, 12'h004, 12'h002, 12'h800};
    int exp_rises [4] = '{2, 2, 2, 8};

    initial begin
        bit ok;
        int rises, busy_cnt, max_dout;
        logic last;

        // Reset with pads held and play requested.
        RST = 1'b1; btn = 12'hFFF; play_en = 1'b1; rec_en = 1'b0; clear = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        chk("rst_Dout", int'(Dout), 0);
        chk("rst_playing", int'(playing), 0);
        chk("rst_pad_led", int'(pad_led), 0);
        chk("rst_Pout", int'(Pout), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge CLK); RST = 1'b0; btn = '0;
        @(posedge CLK); #3;
        chk("rel_playing", int'(playing), 1);
        chk("rel_step", int'(step_idx), 0);
        chk("rel_Dout", int'(Dout), 0);

        // Record: pad0 in step0, pad2 in step1, pads4+1 then pad7 in step2,
        // pad11 on the terminal cycle of step3, then a loop with no presses.
        @(negedge CLK); play_en = 1'b0;
        @(negedge CLK); rec_en = 1'b1;
        wait_n(1);
        wait_n(10);     btn = 12'h001;
        wait_n(5);      btn = '0;
        wait_n(SD - 6); btn = 12'h004;
        wait_n(5);      btn = '0;
        wait_n(SD - 5); btn = 12'h012;
        wait_n(3);      btn = '0;
        wait_n(20);     btn = 12'h080;
        wait_n(3);      btn = '0;
        wait_n(2 * SD - 36); btn = 12'h800;
        wait_n(4);      btn = '0;
        wait_n(4 * SD);
        rec_en = 1'b0; play_en = 1'b1;

        // Playback of one whole loop: codes, LEDs and tone rises per step.
        align_to_step(0, ok);
        if (ok) begin
            for (int k = 0; k < ST; k++) begin
                chk("play_code", int'(Dout), exp_code[k]);
                chk("play_led", int'(pad_led), exp_ledv[k]);
                chk("play_step_start_Pout", int'(Pout), 0);
                rises = 0;
                last = Pout;
                for (int c = 1; c < SD; c++) begin
                    @(posedge CLK); #3;
                    if (Pout && !last) rises++;
                    last = Pout;
                end
                chk("play_tone_rises", rises, exp_rises[k]);
                @(posedge CLK); #3;
            end
        end

        // Clear from PLAY at step 2.
        align_to_step(2, ok);
        @(negedge CLK); clear = 1'b1;
        @(negedge CLK); clear = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            @(negedge CLK);
        end
        chk("clear_busy_cycles", busy_cnt, ST);
        max_dout = 0;
        for (int i = 0; i < ST * SD; i++) begin
            @(negedge CLK);
            if (int'(Dout) > max_dout) max_dout = int'(Dout);
        end
        chk("clear_replay_max", max_dout, 0);
        chk("clear_playing", int'(playing), 1);

        // Reset on the terminal cycle of a step with a pending press.
        play_en = 1'b0; rec_en = 1'b0;
        wait_n(2);
        rec_en = 1'b1;
        wait_n(1);
        wait_n(5);      btn = 12'h020;
        wait_n(3);      btn = '0;
        wait_n(SD - 9); RST = 1'b1;
        wait_n(1);
        chk("rrst_Dout", int'(Dout), 0);
        chk("rrst_recording", int'(recording), 0);
        chk("rrst_playing", int'(playing), 0);
        chk("rrst_step", int'(step_idx), 0);
        chk("rrst_pad_led", int'(pad_led), 0);
        RST = 1'b0; rec_en = 1'b0; play_en = 1'b1;
        wait_n(3);
        chk("rrst_play_Dout", int'(Dout), 0);
        chk("rrst_play_playing", int'(playing), 1);

        // Random traffic.
        rec_en = 1'b1;
        for (int c = 0; c < 24000; c++) begin
            @(negedge CLK);
            RST   = ($urandom_range(0, 4999) == 0);
            clear = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 399) == 0) rec_en = ~rec_en;
            if ($urandom_range(0, 299) == 0) play_en = ~play_en;
            if ($urandom_range(0, 15) == 0) btn = NP'($urandom & $urandom & $urandom);
        end
        @(negedge CLK);
        RST = 1'b0; clear = 1'b0;
        wait_n(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
